uart_alu_sequencer: RTL and testbench
=====================================

Name: uart_alu_sequencer

Overview:
- Control FSM between the UART RX/TX pair and the combinational ALU.
- Collects three received bytes in order (operand A, operand B, opcode), drives them to the ALU, latches the result, then launches one TX transfer carrying it.
- Uses baud ticks from the baud-rate generator for an inter-byte timeout, so a partial frame cannot leave the FSM stuck.

Parameters:
NB_DATA, 8, data/operand/result width
NB_OP, 6, ALU opcode width; taken from the low NB_OP bits of the third byte
N_TIMEOUT, 4096, baud ticks allowed between bytes of one frame
NB_TIMEOUT, 12, width of the timeout counter; must satisfy 2^NB_TIMEOUT >= N_TIMEOUT

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_tick  in  1  baud tick from the baud-rate generator, one-cycle pulse
i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse, byte received
i_tx_done  in  1  one-cycle pulse, TX finished its frame
i_alu_result  in  NB_DATA  combinational ALU result
o_alu_a  out  NB_DATA  operand A register
o_alu_b  out  NB_DATA  operand B register
o_alu_op  out  NB_OP  opcode register
o_tx_data  out  NB_DATA  latched result for TX
o_tx_start  out  1  one-cycle TX start pulse
o_busy  out  1  high in EXEC, SEND and WAIT_TX
o_timeout  out  1  one-cycle pulse, frame aborted by timeout
o_overrun  out  1  one-cycle pulse, byte dropped while busy

Behaviour:
- Fixed interface: one clock, i_clock; reset is synchronous and active-high, on i_reset.
- Reset: state=ST_A; A, B, OP, result and timeout counter=0; all outputs 0.
- Reset has priority over every other event, including in mid-frame or mid-TX.
  - o_tx_start is 0 from the edge that samples i_reset=1.
- All outputs are registers or pure decodes of the state register; there is no combinational path from inputs to outputs.
- o_alu_a/b/op are driven continuously from their registers.
- ST_A: on i_rx_done, A<=i_rx_data, counter<=0, go to ST_B. No timeout is active in ST_A.
- ST_B: on i_rx_done, B<=i_rx_data, counter<=0, go to ST_OP.
- ST_OP: on i_rx_done, OP<=i_rx_data[NB_OP-1:0], go to ST_EXEC.
- Timeout (ST_B and ST_OP only):
  - Each i_tick increments the counter.
  - An i_tick while counter==N_TIMEOUT-1 (and i_rx_done=0) does three things: go to ST_A, pulse o_timeout for 1 cycle, clear the counter.
  - A, B and OP keep their values after a timeout.
  - Same-cycle i_rx_done and terminal tick: the byte wins and no timeout occurs.
- ST_EXEC (exactly 1 cycle): result<=i_alu_result, go to ST_SEND.
- ST_SEND (exactly 1 cycle): o_tx_start=1, o_tx_data=result, go to ST_WAIT_TX.
- ST_WAIT_TX: wait for i_tx_done, then go to ST_A. There is no TX timeout.
- o_tx_data holds its value until the next ST_EXEC.
- Latency: if the edge that samples the opcode's i_rx_done is edge k:
  - EXEC is cycle k+1;
  - o_tx_start is high for exactly the cycle between edges k+2 and k+3.
- Overrun: an i_rx_done in EXEC, SEND or WAIT_TX drops the byte and pulses o_overrun on the next cycle. No register changes.
- An i_tx_done outside ST_WAIT_TX is ignored.
- i_tick outside ST_B/ST_OP is ignored.

Test Plan:
- Bench ALU model result=A+B. Rx bytes 0x05, 0x03, 0x20 -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20, o_tx_data=0x08, single o_tx_start exactly 2 cycles after the opcode-sampling edge. Then i_tx_done -> ST_A, o_busy=0.
- N_TIMEOUT=4: rx 0x11, then 4 i_tick with no byte -> o_timeout pulses once on the 4th tick. Next bytes 0x01, 0x02, 0x20 -> result 0x03, proving resync.
- N_TIMEOUT=4: rx 0x11, 3 ticks, then i_rx_done together with the 4th tick -> no o_timeout, byte stored as B.
- Rx 0x01, 0x01, 0x20; second rx_done during WAIT_TX with 0xAA -> o_overrun pulse, A stays 0x01, no extra o_tx_start.
- i_reset=1 for 1 cycle during ST_WAIT_TX and during ST_OP -> all outputs 0 next cycle. A fresh 3-byte frame 0xFF, 0x01, 0x20 -> o_tx_data=0x00 (wrap-around).
- Two back-to-back frames, the second starting the cycle after i_tx_done -> two o_tx_start pulses with the correct results.

Source files
------------

// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between UART RX/TX and the combinational ALU: gathers
// operand A, operand B and opcode bytes, captures the ALU result and sends it.
module uart_alu_sequencer #(
   parameter int unsigned NB_DATA    = 8,
   parameter int unsigned NB_OP      = 6,
   parameter int unsigned N_TIMEOUT  = 4096,
   parameter int unsigned NB_TIMEOUT = 12
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic               i_tx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_timeout,
   output logic               o_overrun
);

   localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(N_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_A,
      ST_B,
      ST_OP,
      ST_EXEC,
      ST_SEND,
      ST_WAIT_TX
   } state_t;

   state_t                state_q, state_d;
   logic [NB_DATA-1:0]    a_q, a_d;
   logic [NB_DATA-1:0]    b_q, b_d;
   logic [NB_OP-1:0]      op_q, op_d;
   logic [NB_DATA-1:0]    result_q, result_d;
   logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;
   logic                  tx_start_q, tx_start_d;
   logic                  timeout_q, timeout_d;
   logic                  overrun_q, overrun_d;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= ST_A;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         result_q   <= '0;
         cnt_q      <= '0;
         tx_start_q <= 1'b0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         result_q   <= result_d;
         cnt_q      <= cnt_d;
         tx_start_q <= tx_start_d;
         timeout_q  <= timeout_d;
         overrun_q  <= overrun_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      result_d   = result_q;
      cnt_d      = cnt_q;
      tx_start_d = 1'b0;
      timeout_d  = 1'b0;
      overrun_d  = 1'b0;
      case (state_q)
         ST_A: begin
            if (i_rx_done) begin
               a_d     = i_rx_data;
               cnt_d   = '0;
               state_d = ST_B;
            end
         end
         ST_B, ST_OP: begin
            // A received byte beats a terminal tick arriving in the same cycle
            if (i_rx_done) begin
               if (state_q == ST_B) begin
                  b_d     = i_rx_data;
                  cnt_d   = '0;
                  state_d = ST_OP;
               end else begin
                  op_d    = i_rx_data[NB_OP-1:0];
                  state_d = ST_EXEC;
               end
            end else if (i_tick) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d     = '0;
                  timeout_d = 1'b1;
                  state_d   = ST_A;
               end else begin
                  cnt_d = cnt_q + NB_TIMEOUT'(1);
               end
            end
         end
         ST_EXEC: begin
            result_d  = i_alu_result;
            overrun_d = i_rx_done;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            tx_start_d = 1'b1;
            overrun_d  = i_rx_done;
            state_d    = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            overrun_d = i_rx_done;
            if (i_tx_done) begin
               state_d = ST_A;
            end
         end
         default: state_d = ST_A;
      endcase
   end

   assign o_alu_a    = a_q;
   assign o_alu_b    = b_q;
   assign o_alu_op   = op_q;
   assign o_tx_data  = result_q;
   assign o_tx_start = tx_start_q;
   assign o_timeout  = timeout_q;
   assign o_overrun  = overrun_q;
   assign o_busy     = (state_q == ST_EXEC) || (state_q == ST_SEND) || (state_q == ST_WAIT_TX);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer with an A+B ALU model and a
// scoreboard of expected TX results and launch edges.
module tb_uart_alu_sequencer;

   localparam int unsigned NB_DATA = 8;
   localparam int unsigned NB_OP   = 6;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               tick = 1'b0;
   logic [NB_DATA-1:0] rx_data = '0;
   logic               rx_done = 1'b0;
   logic               tx_done = 1'b0;
   logic [NB_DATA-1:0] alu_result;
   logic [NB_DATA-1:0] alu_a, alu_b, tx_data;
   logic [NB_OP-1:0]   alu_op;
   logic               tx_start, busy, timeout, overrun;

   uart_alu_sequencer #(
      .NB_DATA(NB_DATA), .NB_OP(NB_OP), .N_TIMEOUT(4), .NB_TIMEOUT(2)
   ) dut (
      .i_clock(clk), .i_reset(rst), .i_tick(tick),
      .i_rx_data(rx_data), .i_rx_done(rx_done), .i_tx_done(tx_done),
      .i_alu_result(alu_result),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
      .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy),
      .o_timeout(timeout), .o_overrun(overrun)
   );

   // ALU model used by the bench: result = A + B (wraps at 8 bits)
   assign alu_result = alu_a + alu_b;

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic [7:0] res;
   } vec_t;

   typedef struct {
      logic [7:0] res;
      int         edge_no;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   edge_cnt = 0;
   int   to_cnt = 0;
   int   to_edge = -1;
   int   ovr_cnt = 0;
   int   ovr_edge = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample outputs on the falling edge, then advance past the rising edge
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (timeout) begin to_cnt++; to_edge = edge_cnt; end
      if (overrun) begin ovr_cnt++; ovr_edge = edge_cnt; end
      if (tx_start) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_tx_start", 32'(tx_start), 32'(0));
         end else begin
            e = sb_q.pop_front();
            chk("tx_data", 32'(tx_data), 32'(e.res));
            chk("tx_start_edge", 32'(edge_cnt), 32'(e.edge_no));
         end
      end
      @(posedge clk);
      edge_cnt++;
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
   endtask

   task automatic send_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic all_zero(input string name);
      chk(name, 32'({alu_a, alu_b, alu_op, tx_data, tx_start, busy, timeout, overrun}), 32'(0));
   endtask

   // mode 0: normal finish with tx_done; 1: inject overrun byte in WAIT_TX; 2: reset in WAIT_TX
   task automatic finish_frame(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] op, input logic [7:0] res, input int mode);
      exp_t e;
      int   n;
      int   ov0;
      int   e0;
      e.res     = res;
      e.edge_no = edge_cnt + 3;
      sb_q.push_back(e);
      send_byte(op);
      chk("alu_a", 32'(alu_a), 32'(a));
      chk("alu_b", 32'(alu_b), 32'(b));
      chk("alu_op", 32'(alu_op), 32'(op[NB_OP-1:0]));
      chk("busy_exec", 32'(busy), 32'(1));
      n = 0;
      while (sb_q.size() != 0 && n < 10) begin
         step();
         n++;
      end
      chk("tx_start_seen", 32'(sb_q.size()), 32'(0));
      sb_q.delete();
      chk("busy_wait_tx", 32'(busy), 32'(1));
      if (mode == 1) begin
         ov0 = ovr_cnt;
         e0  = edge_cnt;
         send_byte(8'hAA);
         step();
         chk("overrun_count", 32'(ovr_cnt - ov0), 32'(1));
         chk("overrun_edge", 32'(ovr_edge), 32'(e0 + 1));
         chk("a_after_overrun", 32'(alu_a), 32'(a));
         chk("busy_after_overrun", 32'(busy), 32'(1));
      end
      if (mode == 2) begin
         rst = 1'b1;
         step();
         rst = 1'b0;
         all_zero("reset_in_wait_tx");
      end else begin
         tx_done = 1'b1;
         step();
         tx_done = 1'b0;
         chk("busy_after_tx_done", 32'(busy), 32'(0));
      end
   endtask

   task automatic send_frame(input vec_t v, input int mode);
      send_byte(v.a);
      send_byte(v.b);
      finish_frame(v.a, v.b, v.op, v.res, mode);
   endtask

   vec_t vecs[5];
   int   t0;
   int   e0;

   initial begin
      vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, res: 8'h08};
      vecs[1] = '{a: 8'h10, b: 8'h22, op: 8'hE1, res: 8'h32};
      vecs[2] = '{a: 8'h80, b: 8'h80, op: 8'h3F, res: 8'h00};
      vecs[3] = '{a: 8'h7F, b: 8'h01, op: 8'h20, res: 8'h80};
      vecs[4] = '{a: 8'hFF, b: 8'h01, op: 8'h20, res: 8'h00};

      step();
      step();
      rst = 1'b0;
      all_zero("reset_state");

      // Back-to-back frames: each starts the cycle after the previous tx_done
      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i], 0);
      end

      // Ticks and tx_done in ST_A are ignored
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      for (int i = 0; i < 6; i++) send_tick();
      chk("idle_ticks_no_timeout", 32'(to_cnt), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));

      // Inter-byte timeout on the 4th tick, then resync
      send_byte(8'h11);
      for (int i = 0; i < 3; i++) send_tick();
      t0 = to_cnt;
      e0 = edge_cnt;
      send_tick();
      step();
      chk("timeout_count", 32'(to_cnt - t0), 32'(1));
      chk("timeout_edge", 32'(to_edge), 32'(e0 + 1));
      chk("a_kept_after_timeout", 32'(alu_a), 32'(8'h11));
      send_frame('{a: 8'h01, b: 8'h02, op: 8'h20, res: 8'h03}, 0);

      // Byte arriving with the terminal tick wins
      send_byte(8'h11);
      for (int i = 0; i < 3; i++) send_tick();
      t0 = to_cnt;
      tick = 1'b1;
      send_byte(8'h22);
      tick = 1'b0;
      step();
      chk("no_timeout_on_tie", 32'(to_cnt - t0), 32'(0));
      chk("tie_byte_is_b", 32'(alu_b), 32'(8'h22));
      finish_frame(8'h11, 8'h22, 8'h20, 8'h33, 0);

      // Overrun while waiting for TX
      send_frame('{a: 8'h01, b: 8'h01, op: 8'h20, res: 8'h02}, 1);
      for (int i = 0; i < 4; i++) step();

      // Reset during WAIT_TX and during ST_OP
      send_frame('{a: 8'h05, b: 8'h03, op: 8'h20, res: 8'h08}, 2);
      send_byte(8'h01);
      send_byte(8'h02);
      rst = 1'b1;
      step();
      rst = 1'b0;
      all_zero("reset_in_st_op");
      send_frame(vecs[4], 0);
      chk("wrap_tx_data", 32'(tx_data), 32'(8'h00));
      chk("overrun_total", 32'(ovr_cnt), 32'(1));
      chk("timeout_total", 32'(to_cnt), 32'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
